// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
package mouse_pkg;

  localparam int PS2_BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} bit_state_e;
  typedef enum logic [1:0] {B0, B1, B2} pkt_state_e;

  typedef struct packed {
    logic [2:0] buttons;  // {middle, right, left}
    logic [1:0] sign;     // {y, x}
    logic [1:0] ovf;      // {y, x}
    logic [7:0] dx;
    logic [7:0] dy;
  } ps2_pkt_t;

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 byte receiver: synchroniser, falling-edge detect, bit FSM and optional
// mid-frame timeout (enabled by defining MOUSE_TIMEOUT_EN).
module ps2_byte_rx
  import mouse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
`ifdef MOUSE_TIMEOUT_EN
  input  logic                  pkt_busy,
`endif
  output logic [PS2_BYTE_W-1:0] rx_byte,
  output logic                  byte_valid,
  output logic                  byte_err,
  output logic                  abort
);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev, clk_s, data_s, fall;
  bit_state_e             state, state_n;
  logic [2:0]             bit_cnt;
  logic [PS2_BYTE_W-1:0]  shreg;
  logic                   par_bit, valid_n, err_n, to_hit;

  // Synchroniser stage; idle PS/2 lines are high, so reset to 1 avoids a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

`ifdef MOUSE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            busy;

  assign busy   = (state != IDLE) || pkt_busy;
  assign to_hit = busy && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      abort  <= 1'b0;
    end else begin
      abort <= to_hit;
      if (fall || to_hit || !busy) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // No counter in this build: the abort path is constant-false.
  assign to_hit = (TIMEOUT_CYC < 0);
  assign abort  = 1'b0;
`endif

  always_comb begin
    state_n = state;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (to_hit) begin
      state_n = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_s) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (data_s && (^{shreg, par_bit})) valid_n = 1'b1;
          else                               err_n   = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      state      <= state_n;
      byte_valid <= valid_n;
      byte_err   <= err_n;
      if (fall && state == IDLE)      bit_cnt <= '0;
      else if (fall && state == DATA) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Shift register stage: LSB arrives first.
  always_ff @(posedge clk) begin
    if (fall && state == DATA)   shreg   <= {data_s, shreg[PS2_BYTE_W-1:1]};
    if (fall && state == PARITY) par_bit <= data_s;
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: packet assembly, deltas, deadzoned flags, clamped cursor.
// Optional mid-frame timeout is enabled by defining MOUSE_TIMEOUT_EN.
module ps2_mouse_ctrl
  import mouse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEADZONE    = 5,
  parameter int SPEED_SHIFT = 0,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int POS_W       = 10,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PS2Clk,
  input  logic              PS2Data,
  output logic              pkt_valid,
  output logic signed [8:0] dx,
  output logic signed [8:0] dy,
  output logic              left,
  output logic              right,
  output logic              middle,
  output logic              x_pos,
  output logic              x_neg,
  output logic              y_pos,
  output logic              y_neg,
  output logic [POS_W-1:0]  cursor_x,
  output logic [POS_W-1:0]  cursor_y,
  output logic              ovf,
  output logic              err
);

  localparam logic signed [8:0]       DZ    = 9'(DEADZONE);
  localparam logic signed [POS_W+1:0] X_MAX = (POS_W + 2)'(SCREEN_W - 1);
  localparam logic signed [POS_W+1:0] Y_MAX = (POS_W + 2)'(SCREEN_H - 1);

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [POS_W+1:0] v,
                                                 input logic signed [POS_W+1:0] hi);
    if (v < 0)       return '0;
    else if (v > hi) return hi[POS_W-1:0];
    else             return v[POS_W-1:0];
  endfunction

  logic [PS2_BYTE_W-1:0]    rx_byte;
  logic                     byte_valid, byte_err, abort;
  pkt_state_e               pstate, pstate_n;
  logic                     commit, err_n;
  logic [6:0]               hdr_p0;
  logic [PS2_BYTE_W-1:0]    b1_p0;
  ps2_pkt_t                 pkt;
  logic signed [8:0]        dx_new, dy_new;
  logic signed [POS_W+1:0]  step_x, step_y, nx, ny;

  ps2_byte_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (PS2Clk),
    .ps2_data   (PS2Data),
`ifdef MOUSE_TIMEOUT_EN
    .pkt_busy   (pstate != B0),
`endif
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .abort      (abort)
  );

  always_comb begin
    pstate_n = pstate;
    commit   = 1'b0;
    err_n    = 1'b0;
    if (abort || byte_err) begin
      pstate_n = B0;
      err_n    = 1'b1;
    end else if (byte_valid) begin
      case (pstate)
        B0: if (rx_byte[3]) pstate_n = B1;
            else            err_n    = 1'b1;
        B1: pstate_n = B2;
        B2: begin
          pstate_n = B0;
          commit   = 1'b1;
        end
        default: pstate_n = B0;
      endcase
    end
  end

  // Header/first-delta capture stage; bit3 is only a sync marker and is not kept.
  always_ff @(posedge clk) begin
    if (byte_valid && pstate == B0) hdr_p0 <= {rx_byte[7:4], rx_byte[2:0]};
    if (byte_valid && pstate == B1) b1_p0  <= rx_byte;
  end

  assign pkt    = '{buttons: hdr_p0[2:0], sign: hdr_p0[4:3], ovf: hdr_p0[6:5],
                    dx: b1_p0, dy: rx_byte};
  assign dx_new = {pkt.sign[0], pkt.dx};
  assign dy_new = {pkt.sign[1], pkt.dy};
  assign step_x = (POS_W + 2)'(dx_new >>> SPEED_SHIFT);
  assign step_y = (POS_W + 2)'(dy_new >>> SPEED_SHIFT);
  assign nx     = $signed({2'b00, cursor_x}) + step_x;
  assign ny     = $signed({2'b00, cursor_y}) - step_y;

  // Commit stage: all packet outputs update together with pkt_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pstate    <= B0;
      pkt_valid <= 1'b0;
      err       <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      {middle, right, left}       <= '0;
      {x_pos, x_neg, y_pos, y_neg} <= '0;
      ovf       <= 1'b0;
      cursor_x  <= POS_W'(SCREEN_W / 2);
      cursor_y  <= POS_W'(SCREEN_H / 2);
    end else begin
      pstate    <= pstate_n;
      pkt_valid <= commit;
      err       <= err_n;
      if (commit) begin
        dx    <= dx_new;
        dy    <= dy_new;
        {middle, right, left} <= pkt.buttons;
        x_pos <= dx_new > DZ;
        x_neg <= dx_new < -DZ;
        y_pos <= dy_new > DZ;
        y_neg <= dy_new < -DZ;
        ovf   <= |pkt.ovf;
        if (~|pkt.ovf) begin
          cursor_x <= clamp_pos(nx, X_MAX);
          cursor_y <= clamp_pos(ny, Y_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Scoreboard bench for ps2_mouse_ctrl; timeout scenario runs when MOUSE_TIMEOUT_EN is defined.
module tb_ps2_mouse_ctrl;

  localparam int TO_CYC = 2000;
  localparam int H      = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic              pkt_valid, left, right, middle, x_pos, x_neg, y_pos, y_neg, ovf, err;
  logic signed [8:0] dx, dy;
  logic [9:0]        cursor_x, cursor_y;

  always #5 clk = ~clk;

  ps2_mouse_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .PS2Clk    (ps2_clk),
    .PS2Data   (ps2_data),
    .pkt_valid (pkt_valid),
    .dx        (dx),
    .dy        (dy),
    .left      (left),
    .right     (right),
    .middle    (middle),
    .x_pos     (x_pos),
    .x_neg     (x_neg),
    .y_pos     (y_pos),
    .y_neg     (y_neg),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .ovf       (ovf),
    .err       (err)
  );

  typedef struct {
    bit is_err;
    int dx, dy, btn, flags, cx, cy, ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic void check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // flags packed as {x_pos, x_neg, y_pos, y_neg}; btn as {middle, right, left}
  task automatic push_pkt(input int pdx, input int pdy, input int btn, input int flags,
                          input int cx, input int cy, input int povf);
    exp_t e;
    e.is_err = 1'b0; e.dx = pdx; e.dy = pdy; e.btn = btn; e.flags = flags;
    e.cx = cx; e.cy = cy; e.ovf = povf;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e = '{1'b1, 0, 0, 0, 0, 0, 0, 0};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && (pkt_valid || err)) begin
      check("pulse_exclusive", int'(pkt_valid && err), 0);
      if (q.size() == 0) begin
        check("event_with_empty_queue", int'({pkt_valid, err}), 0);
      end else begin
        mon_e = q.pop_front();
        check("event_kind_err", int'(err), int'(mon_e.is_err));
        if (!mon_e.is_err) begin
          check("dx", int'(dx), mon_e.dx);
          check("dy", int'(dy), mon_e.dy);
          check("buttons", int'({middle, right, left}), mon_e.btn);
          check("dir_flags", int'({x_pos, x_neg, y_pos, y_neg}), mon_e.flags);
          check("cursor_x", int'(cursor_x), mon_e.cx);
          check("cursor_y", int'(cursor_y), mon_e.cy);
          check("ovf", int'(ovf), mon_e.ovf);
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cursor_x"}, int'(cursor_x), 320);
    check({tag, "_cursor_y"}, int'(cursor_y), 240);
    check({tag, "_dx"}, int'(dx), 0);
    check({tag, "_dy"}, int'(dy), 0);
    check({tag, "_buttons"}, int'({middle, right, left}), 0);
    check({tag, "_flags"}, int'({x_pos, x_neg, y_pos, y_neg}), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_pulses"}, int'({pkt_valid, err}), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, pending=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int xs[5];
    xs = '{454, 581, 639, 639, 639};

    do_reset();
    check_reset_state("reset");
    repeat (1000) @(negedge clk);
    check("idle_cursor_x", int'(cursor_x), 320);
    check("idle_cursor_y", int'(cursor_y), 240);

    // +10 right, 10 down (y sign set)
    push_pkt(10, -10, 0, 4'b1001, 330, 250, 0);
    send_pkt(8'h28, 8'h0A, 8'hF6);

    // -3 / +3, inside deadzone
    push_pkt(-3, 3, 0, 4'b0000, 327, 247, 0);
    send_pkt(8'h18, 8'hFD, 8'h03);

    // corrupt parity on a header, then left button packet
    push_err();
    send_byte(8'h09, 1'b1);
    push_pkt(0, 0, 1, 4'b0000, 327, 247, 0);
    send_pkt(8'h09, 8'h00, 8'h00);

    // header without sync bit, then right edge clamp
    push_err();
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push_pkt(127, 0, 0, 4'b1000, xs[i], 247, 0);
      send_pkt(8'h08, 8'h7F, 8'h00);
    end

    // large upward move, then top clamp and deadzone boundaries
    push_pkt(10, 246, 0, 4'b1010, 639, 1, 0);
    send_pkt(8'h08, 8'h0A, 8'hF6);
    push_pkt(0, 5, 0, 4'b0000, 639, 0, 0);
    send_pkt(8'h08, 8'h00, 8'h05);
    push_pkt(0, -6, 0, 4'b0001, 639, 6, 0);
    send_pkt(8'h28, 8'h00, 8'hFA);
    push_pkt(-5, -5, 0, 4'b0000, 634, 11, 0);
    send_pkt(8'h38, 8'hFB, 8'hFB);

    // overflow bits set: cursor frozen, buttons right+middle
    push_pkt(80, 80, 6, 4'b1010, 634, 11, 1);
    send_pkt(8'hCE, 8'h50, 8'h50);
    drain();

`ifdef MOUSE_TIMEOUT_EN
    push_err();
    send_byte(8'h08, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO_CYC + 200) @(negedge clk);
    check("timeout_err_seen", q.size(), 0);
    push_pkt(2, 0, 0, 4'b0000, 636, 11, 0);
    send_pkt(8'h08, 8'h02, 8'h00);
    drain();
`endif

    // reset in the middle of a byte
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    do_reset();
    check_reset_state("midbyte_reset");
    push_pkt(1, 1, 1, 4'b0000, 321, 239, 0);
    send_pkt(8'h09, 8'h01, 8'h01);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
